// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit restoring divider for DIV/DIVU/REM/REMU
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] result_q, result_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        special_q, special_d;

   logic        is_signed;
   logic        div_zero;
   logic        overflow;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] fix_val;

   // Operand decode, one restoring step, and sign correction of the finished result
   always_comb begin
      is_signed = ~op[0];
      div_zero  = (divisor == 32'd0);
      overflow  = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      abs_a     = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
      abs_b     = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
      // Remainder can reach 33 bits after the shift; bit 32 of the difference is the borrow
      shifted   = {rem_q, quo_q[31]};
      trial     = shifted - {1'b0, dvs_q};
      // Special-case values were preloaded in final form and bypass negation
      quo_fix   = (!special_q && !op_q[0] && neg_quo_q) ? (32'd0 - quo_q) : quo_q;
      rem_fix   = (!special_q && !op_q[0] && neg_rem_q) ? (32'd0 - rem_q) : rem_q;
      fix_val   = op_q[1] ? rem_fix : quo_fix;
   end

   // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      special_d = special_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = op;
               if (div_zero) begin
                  quo_d     = 32'hFFFF_FFFF;
                  rem_d     = dividend;
                  special_d = 1'b1;
                  state_d   = S_FIX;
               end else if (overflow) begin
                  quo_d     = 32'h8000_0000;
                  rem_d     = 32'd0;
                  special_d = 1'b1;
                  state_d   = S_FIX;
               end else begin
                  quo_d     = abs_a;
                  rem_d     = 32'd0;
                  dvs_d     = abs_b;
                  neg_quo_d = is_signed && (dividend[31] ^ divisor[31]);
                  neg_rem_d = dividend[31];
                  cnt_d     = 6'd32;
                  special_d = 1'b0;
                  state_d   = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = trial[32] ? shifted[31:0] : trial[31:0];
            quo_d = {quo_q[30:0], ~trial[32]};
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = fix_val;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= 2'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_q     <= 32'd0;
         result_q  <= 32'd0;
         cnt_q     <= 6'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         special_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         special_q <= special_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] result;

   div_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t        expq[$];
   exp_t        cur;
   logic [31:0] held      = 32'd0;
   int          busy_from = -1;
   int          busy_to   = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
      return o[1] ? (a % b) : (a / b);
   endfunction

   function automatic int lat_of(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 2;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   // Called at a falling edge while the unit is idle
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      start    = 1'b1;
      op       = o;
      dividend = a;
      divisor  = b;
      e.res    = model(o, a, b);
      e.due    = cyc + lat_of(o, a, b);
      expq.push_back(e);
      busy_from = cyc + 1;
      busy_to   = e.due;
   endtask

   task automatic model_reset();
      expq.delete();
      held      = 32'd0;
      busy_from = -1;
      busy_to   = -1;
   endtask

   // Returns at the falling edge of the done cycle (or after the bound expires)
   task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_lit, input int lat_lit);
      int n;
      @(negedge clk);
      issue(o, a, b);
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      n = 1;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         check({name, "_timeout"}, 32'(n), 32'(lat_lit));
      end else begin
         check({name, "_result"}, result, exp_lit);
         check({name, "_latency"}, 32'(n), 32'(lat_lit));
      end
   endtask

   // Cycle-by-cycle comparison of busy, done timing and result against the model
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from && cyc <= busy_to)});
         if (done) begin
            if (expq.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               cur = expq.pop_front();
               check("done_cycle", 32'(cyc), 32'(cur.due));
               check("result", result, cur.res);
               held = cur.res;
            end
         end else begin
            if (expq.size() > 0 && cyc >= expq[0].due) begin
               check("done_missing", 32'(cyc), 32'(expq[0].due));
               void'(expq.pop_front());
            end
            check("result_hold", result, held);
         end
      end
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      op       = 2'd0;
      dividend = 32'd0;
      divisor  = 32'd0;
      #1;
      check("reset_busy",   {31'd0, busy}, 32'd0);
      check("reset_done",   {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);

      check("model_divu", model(2'b01, 32'd100, 32'd7), 32'd14);
      check("model_remu", model(2'b11, 32'd100, 32'd7), 32'd2);
      check("model_div_neg", model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("model_rem_neg", model(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);

      repeat (2) @(negedge clk);
      rst = 1'b0;

      run("divu_100_7",    2'b01, 32'd100,        32'd7,          32'd14,         34);
      run("remu_100_7",    2'b11, 32'd100,        32'd7,          32'd2,          34);
      run("div_m7_2",      2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
      run("rem_m7_2",      2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
      run("div_7_m2",      2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34);
      run("rem_7_m2",      2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34);
      run("div_5_0",       2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  2);
      run("remu_x_0",      2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  2);
      run("divu_5_0",      2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  2);
      run("rem_0_0",       2'b10, 32'd0,          32'd0,          32'd0,          2);
      run("div_ovf",       2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2);
      run("rem_ovf",       2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2);
      run("divu_ovf_pat",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);
      run("div_min_1",     2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34);
      run("divu_max_1",    2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34);

      // Handshake: starts during CALC and DONE ignored, start right after done accepted
      @(negedge clk);
      issue(2'b01, 32'd1000, 32'd10);
      for (int n = 1; n <= 34; n++) begin
         @(negedge clk);
         start = (n == 10 || n == 34);
         if (start) begin
            op       = 2'b00;
            dividend = 32'd9;
            divisor  = 32'd3;
         end
         if (n == 34) begin
            check("hs_done", {31'd0, done}, 32'd1);
            check("hs_first_result", result, 32'd100);
         end
      end
      @(negedge clk);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      begin
         int n;
         @(negedge clk);
         start = 1'b0;
         n = 1;
         while (!done && n < 60) begin
            @(negedge clk);
            n++;
         end
         check("hs_second_latency", 32'(n), 32'd34);
         check("hs_second_result", result, 32'hFFFF_FFFF);
      end

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      issue(2'b01, 32'd100, 32'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("midreset_busy",   {31'd0, busy}, 32'd0);
      check("midreset_done",   {31'd0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(2'b00, 32'd100, 32'hFFFF_FFF9);
      begin
         int n;
         @(negedge clk);
         start = 1'b0;
         n = 1;
         while (!done && n < 60) begin
            @(negedge clk);
            n++;
         end
         check("post_reset_latency", 32'(n), 32'd34);
         check("post_reset_result", result, 32'hFFFF_FFF2);
      end

      // Random sweep including special-case operand patterns
      for (int i = 0; i < 800; i++) begin
         logic [1:0]  o;
         logic [31:0] a;
         logic [31:0] b;
         int          n;
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: b = {16'd0, 16'($urandom)};
            default: ;
         endcase
         @(negedge clk);
         issue(o, a, b);
         @(negedge clk);
         start    = 1'b0;
         dividend = $urandom;
         divisor  = $urandom;
         n = 1;
         while (!done && n < 60) begin
            @(negedge clk);
            n++;
         end
         if (!done) check("sweep_timeout", 32'(n), 32'(lat_of(o, a, b)));
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
